mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter PAT_LEN, default 4, SHALL be the pattern length in bytes.
REQ-002 Parameter TXT_MAX, default 11064, SHALL be the text capacity in bytes.
REQ-003 Parameter TERM, default 8'h00, SHALL be the text terminator byte, which is never stored.
REQ-004 clk  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 inicio  in  1  SHALL be the load start request, level-sampled in IDLE.
REQ-007 byte_in  in  8  SHALL be the stream data byte.
REQ-008 byte_valid  in  1  SHALL indicate that byte_in is valid.
REQ-009 byte_ready  out  1  SHALL indicate that the loader accepts byte_in this cycle.
REQ-010 pat_we  out  1  SHALL be the pattern memory write strobe.
REQ-011 pat_addr  out  3  SHALL be the pattern memory write address.
REQ-012 pat_data  out  8  SHALL be the pattern memory write data.
REQ-013 txt_we  out  1  SHALL be the text memory write strobe.
REQ-014 txt_addr  out  14  SHALL be the text memory write address.
REQ-015 txt_data  out  8  SHALL be the text memory write data.
REQ-016 text_len  out  14  SHALL be the number of text bytes stored.
REQ-017 busy  out  1  SHALL be high in LOAD_PAT and LOAD_TXT.
REQ-018 done  out  1  SHALL be high in DONE.
REQ-019 overflow  out  1  SHALL be high when the last load ended at capacity rather than on TERM.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, LOAD_PAT, LOAD_TXT and DONE.
REQ-021 IDLE SHALL go to LOAD_PAT when inicio=1, clearing the pattern counter, the text counter, text_len and overflow.
REQ-022 A byte SHALL be accepted only in a cycle where byte_valid=1 and byte_ready=1.
REQ-023 byte_ready SHALL be 1 only in LOAD_PAT and LOAD_TXT, combinationally from the state.
REQ-024 In LOAD_PAT, each accepted byte SHALL drive pat_we=1, pat_addr=count and pat_data=byte_in in that same cycle, then increment count.
REQ-025 After accepting byte PAT_LEN-1, the FSM SHALL go to LOAD_TXT; a TERM byte in LOAD_PAT is stored as data.
REQ-026 In LOAD_TXT, an accepted byte not equal to TERM SHALL drive txt_we=1, txt_addr=text_len and txt_data=byte_in in the same cycle, then increment text_len.
REQ-027 In LOAD_TXT, an accepted TERM byte SHALL drive txt_we=0 and go to DONE with overflow=0.
REQ-028 When the write that makes text_len equal TXT_MAX occurs, the FSM SHALL go to DONE with overflow=1; text_len SHALL never exceed TXT_MAX.
REQ-029 A TERM byte arriving exactly when text_len=TXT_MAX SHALL not be accepted, because the FSM is already in DONE.
REQ-030 A text of zero bytes (TERM first) SHALL end with text_len=0, done=1 and overflow=0.
REQ-031 DONE SHALL hold text_len and overflow until inicio=1, which restarts the load via REQ-021.
REQ-032 pat_we and txt_we SHALL never be high in the same cycle, and never be high outside accept cycles.
REQ-033 inicio SHALL be ignored in LOAD_PAT and LOAD_TXT.
REQ-034 byte_valid=0 cycles SHALL stall the load without changing state or counters.

Reset
REQ-035 rst=0 SHALL asynchronously force IDLE, zero all counters, and set text_len=0, overflow=0, busy=0, done=0, byte_ready=0, pat_we=0 and txt_we=0.
REQ-036 Reset asserted mid-load SHALL abort the load; memory contents already written are not cleared.

Structure
REQ-037 The state enum, PAT_LEN, TXT_MAX and TERM defaults SHALL live in the shared package loader_pkg.
REQ-038 The text address counter SHALL be one sub-module, load_counter, with synchronous clear, enable and a 14-bit output.

Verification
REQ-039 Reset, inicio, stream "HOLA" then "ABHOLAX" then 00 -> pat_addr 0..3 written with 48,4F,4C,41; text_len=7; done=1; overflow=0.
REQ-040 Stream 4 pattern bytes then TXT_MAX non-TERM bytes -> final write at txt_addr=11063; done=1; overflow=1; byte_ready=0 afterwards.
REQ-041 Stream 4 pattern bytes then 00 -> text_len=0; done=1; no txt_we pulse.
REQ-042 Random byte_valid gaps -> identical memory writes and text_len to the gap-free run.
REQ-043 rst=0 after 2 text bytes -> immediate IDLE, all outputs zero; a new inicio reloads correctly.
REQ-044 Pattern byte equal to 00 -> stored at pat_addr; the FSM stays in pattern loading.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and default parameters for the pattern/text memory loader.
package loader_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned PAT_AW      = 3;
    localparam int unsigned TXT_AW      = 14;

    localparam int unsigned PAT_LEN_DEF = 4;
    localparam int unsigned TXT_MAX_DEF = 11064;
    localparam logic [BYTE_W-1:0] TERM_DEF = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_PAT = 2'd1,
        ST_LOAD_TXT = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/load_counter.sv
// Text address counter: synchronous clear has priority over enable.
module load_counter
    import loader_pkg::*;
#(
    parameter int unsigned W = TXT_AW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_loader.sv
// Streams a fixed-length pattern and a TERM-delimited text into two memories.
module mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned        PAT_LEN = PAT_LEN_DEF,
    parameter int unsigned        TXT_MAX = TXT_MAX_DEF,
    parameter logic [BYTE_W-1:0]  TERM    = TERM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inicio,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pat_we,
    output logic [PAT_AW-1:0] pat_addr,
    output logic [BYTE_W-1:0] pat_data,
    output logic              txt_we,
    output logic [TXT_AW-1:0] txt_addr,
    output logic [BYTE_W-1:0] txt_data,
    output logic [TXT_AW-1:0] text_len,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [PAT_AW-1:0] PAT_LAST = PAT_AW'(PAT_LEN - 1);
    localparam logic [TXT_AW-1:0] TXT_LAST = TXT_AW'(TXT_MAX - 1);

    state_e            state_q;
    state_e            state_d;
    logic [PAT_AW-1:0] pat_cnt_q;
    logic [PAT_AW-1:0] pat_cnt_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              txt_clr;
    logic              txt_en;
    logic [TXT_AW-1:0] txt_cnt;

    // Text write address doubles as the stored text length.
    load_counter #(
        .W (TXT_AW)
    ) u_txt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (txt_clr),
        .en  (txt_en),
        .cnt (txt_cnt)
    );

    // Next-state, counter control and same-cycle memory write strobes.
    always_comb begin
        state_d    = state_q;
        pat_cnt_d  = pat_cnt_q;
        ovf_d      = ovf_q;
        txt_clr    = 1'b0;
        txt_en     = 1'b0;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pat_we     = 1'b0;
        pat_data   = '0;
        txt_we     = 1'b0;
        txt_data   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (inicio) begin
                    state_d   = ST_LOAD_PAT;
                    pat_cnt_d = '0;
                    txt_clr   = 1'b1;
                    ovf_d     = 1'b0;
                end
            end

            ST_LOAD_PAT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    // TERM is ordinary data inside the pattern.
                    pat_we   = 1'b1;
                    pat_data = byte_in;
                    if (pat_cnt_q == PAT_LAST) begin
                        state_d   = ST_LOAD_TXT;
                        pat_cnt_d = '0;
                    end else begin
                        pat_cnt_d = pat_cnt_q + PAT_AW'(1);
                    end
                end
            end

            ST_LOAD_TXT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if (byte_in == TERM) begin
                        state_d = ST_DONE;
                        ovf_d   = 1'b0;
                    end else begin
                        txt_we   = 1'b1;
                        txt_data = byte_in;
                        txt_en   = 1'b1;
                        // Filling the last slot ends the load without a TERM.
                        if (txt_cnt == TXT_LAST) begin
                            state_d = ST_DONE;
                            ovf_d   = 1'b1;
                        end
                    end
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (inicio) begin
                    state_d   = ST_LOAD_PAT;
                    pat_cnt_d = '0;
                    txt_clr   = 1'b1;
                    ovf_d     = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pattern counter and overflow flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pat_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_cnt_q <= pat_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pat_addr = pat_cnt_q;
    assign txt_addr = txt_cnt;
    assign text_len = txt_cnt;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a write-capturing memory model.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inicio = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        pat_we;
    logic [2:0]  pat_addr;
    logic [7:0]  pat_data;
    logic        txt_we;
    logic [13:0] txt_addr;
    logic [7:0]  txt_data;
    logic [13:0] text_len;
    logic        busy;
    logic        done;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] pat_mem [0:7];
    logic [7:0] txt_mem [0:16383];
    int txt_wr_cnt    = 0;
    int pat_wr_cnt    = 0;
    int txt_sig       = 0;
    int last_txt_addr = -1;
    int viol          = 0;

    mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .inicio     (inicio),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pat_we     (pat_we),
        .pat_addr   (pat_addr),
        .pat_data   (pat_data),
        .txt_we     (txt_we),
        .txt_addr   (txt_addr),
        .txt_data   (txt_data),
        .text_len   (text_len),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Memory model plus write-strobe legality tracking.
    always @(posedge clk) begin
        if (pat_we) begin
            pat_mem[pat_addr] <= pat_data;
            pat_wr_cnt <= pat_wr_cnt + 1;
        end
        if (txt_we) begin
            txt_mem[txt_addr] <= txt_data;
            txt_wr_cnt <= txt_wr_cnt + 1;
            txt_sig <= txt_sig + int'(txt_addr) * 256 + int'(txt_data);
            last_txt_addr <= int'(txt_addr);
        end
        if ((pat_we && txt_we) || ((pat_we || txt_we) && !(byte_valid && byte_ready)))
            viol <= viol + 1;
    end

    // Runaway guard.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic load_str(input string s, input int maxgap);
        for (int i = 0; i < s.len(); i++)
            send(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic start();
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    initial begin
        string exp_txt;
        int base_cnt;
        int base_sig;
        int ref_sig;

        exp_txt = "ABHOLAX";

        // Reset state.
        #2 rst = 1'b0;
        #10;
        chk("reset_flags", {26'd0, busy, done, byte_ready, overflow, pat_we, txt_we}, 32'd0);
        chk("reset_text_len", 32'(text_len), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {29'd0, busy, done, byte_ready}, 32'd0);

        // Basic load: pattern HOLA, text ABHOLAX, terminator.
        start();
        chk("pat_busy_ready", {30'd0, busy, byte_ready}, 32'h3);
        base_cnt = txt_wr_cnt;
        base_sig = txt_sig;
        load_str("HOLA", 0);
        chk("after_pat_busy", 32'(busy), 32'd1);
        load_str(exp_txt, 0);
        send(8'h00, 0);
        chk("a_text_len", 32'(text_len), 32'd7);
        chk("a_done_ovf", {29'd0, done, overflow, busy}, 32'h4);
        chk("a_ready_low", 32'(byte_ready), 32'd0);
        chk("a_pattern", {pat_mem[0], pat_mem[1], pat_mem[2], pat_mem[3]}, 32'h484F4C41);
        for (int i = 0; i < 7; i++)
            chk($sformatf("a_txt_%0d", i), 32'(txt_mem[i]), 32'(exp_txt[i]));
        chk("a_txt_writes", 32'(txt_wr_cnt - base_cnt), 32'd7);
        ref_sig = txt_sig - base_sig;
        repeat (3) @(negedge clk);
        chk("a_hold", {16'd0, 2'b00, text_len}, 32'd7);
        chk("a_hold_done", 32'(done), 32'd1);

        // Same stream with random gaps; inicio held high during the load.
        start();
        inicio = 1'b1;
        base_cnt = txt_wr_cnt;
        base_sig = txt_sig;
        load_str("HOLA", 3);
        load_str(exp_txt, 3);
        chk("b_still_busy", 32'(busy), 32'd1);
        inicio = 1'b0;
        send(8'h00, 2);
        chk("b_text_len", 32'(text_len), 32'd7);
        chk("b_done_ovf", {30'd0, done, overflow}, 32'h2);
        chk("b_txt_writes", 32'(txt_wr_cnt - base_cnt), 32'd7);
        chk("b_same_writes", 32'(txt_sig - base_sig), 32'(ref_sig));
        chk("b_pattern", {pat_mem[0], pat_mem[1], pat_mem[2], pat_mem[3]}, 32'h484F4C41);

        // Zero byte inside the pattern, then an empty text.
        start();
        send(8'h5A, 0);
        send(8'h00, 0);
        chk("c_pat_zero_busy", {30'd0, busy, done}, 32'h2);
        chk("c_pat_zero_mem", 32'(pat_mem[1]), 32'd0);
        send(8'h51, 0);
        send(8'h52, 0);
        base_cnt = txt_wr_cnt;
        send(8'h00, 0);
        chk("c_text_len", 32'(text_len), 32'd0);
        chk("c_done_ovf", {30'd0, done, overflow}, 32'h2);
        chk("c_no_txt_we", 32'(txt_wr_cnt - base_cnt), 32'd0);
        chk("c_pattern", {pat_mem[0], pat_mem[1], pat_mem[2], pat_mem[3]}, 32'h5A005152);

        // Reset in the middle of the text.
        start();
        load_str("WXYZ", 0);
        send(8'h61, 0);
        send(8'h62, 0);
        chk("d_len_before", 32'(text_len), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("d_reset_flags", {26'd0, busy, done, byte_ready, overflow, pat_we, txt_we}, 32'd0);
        chk("d_reset_addr", {15'd0, pat_addr, txt_addr}, 32'd0);
        chk("d_reset_len", 32'(text_len), 32'd0);
        chk("d_mem_kept", 32'(txt_mem[1]), 32'h62);
        @(negedge clk);
        rst = 1'b1;
        start();
        load_str("HOLA", 0);
        load_str(exp_txt, 0);
        send(8'h00, 0);
        chk("d_reload_len", 32'(text_len), 32'd7);
        chk("d_reload_done", {30'd0, done, overflow}, 32'h2);

        // Capacity overflow.
        start();
        load_str("WXYZ", 0);
        base_cnt = txt_wr_cnt;
        for (int i = 0; i < 11064; i++)
            send(8'h41 + 8'(i % 26), 0);
        chk("e_text_len", 32'(text_len), 32'd11064);
        chk("e_done_ovf", {29'd0, done, overflow, busy}, 32'h6);
        chk("e_ready_low", 32'(byte_ready), 32'd0);
        chk("e_last_addr", 32'(last_txt_addr), 32'd11063);
        chk("e_last_data", 32'(txt_mem[11063]), 32'h4E);
        chk("e_writes", 32'(txt_wr_cnt - base_cnt), 32'd11064);
        send(8'h00, 0);
        chk("e_term_ignored_len", 32'(text_len), 32'd11064);
        chk("e_term_ignored_ovf", {30'd0, done, overflow}, 32'h3);

        // Restart clears overflow.
        start();
        chk("f_restart_ovf", {29'd0, busy, done, overflow}, 32'h4);
        chk("f_restart_len", 32'(text_len), 32'd0);

        chk("strobe_violations", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
